// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - store buffer default sizing and entry field layout
// Purpose: shared defaults for store_buffer and sb_overlap_cmp.
// An entry is packed as {addr, data, size}, with size in the least significant bits.
package sb_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTRW = 2;
    localparam int SB_DATAW = 64;
    localparam int SB_SIZEW = 4;
    localparam int SB_ADDRW = 32;

    localparam int SB_SIZE_LSB = 0;
    localparam int SB_DATA_LSB = SB_SIZE_LSB + SB_SIZEW;
    localparam int SB_ADDR_LSB = SB_DATA_LSB + SB_DATAW;
    localparam int SB_ENTRY_W = SB_ADDR_LSB + SB_ADDRW;
endpackage

// File: rtl/sb_overlap_cmp.sv
// rtl/sb_overlap_cmp.sv - combinational byte-range overlap comparator
// Purpose: flags when the byte ranges [a_addr, a_addr+a_size-1] and
// [b_addr, b_addr+b_size-1] share at least one byte.
// Ports: en (gate), a_addr/a_size (stored range), b_addr/b_size (load range), hit.
module sb_overlap_cmp
    import sb_pkg::*;
#(
    parameter int ADDRW = SB_ADDRW,
    parameter int SIZEW = SB_SIZEW
) (
    input  logic             en,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [SIZEW-1:0] a_size,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [SIZEW-1:0] b_size,
    output logic             hit
);
    logic [ADDRW-1:0] b_minus_a;
    logic [ADDRW-1:0] a_minus_b;
    logic [ADDRW-1:0] a_len;
    logic [ADDRW-1:0] b_len;

    // Distances are taken modulo 2^ADDRW, so a range running past the top of
    // the address space still meets a range that starts at address 0.
    assign b_minus_a = b_addr - a_addr;
    assign a_minus_b = a_addr - b_addr;
    assign a_len     = ADDRW'(a_size);
    assign b_len     = ADDRW'(b_size);

    // A zero-length range touches nothing, whichever side it is on.
    assign hit = en && (a_size != '0) && (b_size != '0) &&
                 ((b_minus_a < a_len) || (a_minus_b < b_len));
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order FIFO store buffer with load-conflict detection
// Purpose: queues retiring stores and drains them one per dmem handshake.
// Ports: clk/reset; st_* store input (valid/ready); dmem_w_* head entry
// output (valid/ready); ld_address/ld_size probe with ld_conflict;
// sb_empty/sb_count occupancy.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTRW  = SB_PTRW,
    parameter int DATAW = SB_DATAW,
    parameter int SIZEW = SB_SIZEW,
    parameter int ADDRW = SB_ADDRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [ADDRW-1:0] st_address,
    input  logic [DATAW-1:0] st_data,
    input  logic [SIZEW-1:0] st_size,
    output logic             dmem_w_valid,
    input  logic             dmem_w_ready,
    output logic [ADDRW-1:0] dmem_w_address,
    output logic             dmem_w_wr_en,
    output logic [DATAW-1:0] dmem_w_wr_data,
    output logic [SIZEW-1:0] dmem_w_wr_size,
    input  logic [ADDRW-1:0] ld_address,
    input  logic [SIZEW-1:0] ld_size,
    output logic             ld_conflict,
    output logic             sb_empty,
    output logic [PTRW:0]    sb_count
);
    localparam int SIZE_LSB = SB_SIZE_LSB;
    localparam int DATA_LSB = SIZE_LSB + SIZEW;
    localparam int ADDR_LSB = DATA_LSB + DATAW;
    localparam int ENTRY_W  = ADDR_LSB + ADDRW;
    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTRW-1:0]    head;
    logic [PTRW-1:0]    tail;
    logic [PTRW:0]      count;
    logic               full;
    logic               push;
    logic               pop;
    logic [DEPTH:0]     hit;

    // Fullness comes only from count; head==tail is ambiguous once pointers wrap.
    // No pop-to-push bypass: a full buffer refuses stores even while draining.
    assign full         = (count == FULL_COUNT);
    assign st_ready     = !full && !reset;
    assign dmem_w_valid = (count != '0) && !reset;
    assign dmem_w_wr_en = dmem_w_valid;
    assign push         = st_valid && st_ready;
    assign pop          = dmem_w_valid && dmem_w_ready;

    assign dmem_w_address = mem[head][ADDR_LSB +: ADDRW];
    assign dmem_w_wr_data = mem[head][DATA_LSB +: DATAW];
    assign dmem_w_wr_size = mem[head][SIZE_LSB +: SIZEW];

    // Count is forced to read empty while reset is held, before the
    // synchronous clear has taken effect.
    assign sb_empty = reset || (count == '0);
    assign sb_count = reset ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {st_address, st_data, st_size};
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTRW-1:0] offset;
        logic            occupied;

        // Slot i holds a live store when it lies within count slots of head.
        assign offset   = PTRW'(i) - head;
        assign occupied = !reset && ({1'b0, offset} < count);

        sb_overlap_cmp #(
            .ADDRW(ADDRW),
            .SIZEW(SIZEW)
        ) u_cmp (
            .en     (occupied),
            .a_addr (mem[i][ADDR_LSB +: ADDRW]),
            .a_size (mem[i][SIZE_LSB +: SIZEW]),
            .b_addr (ld_address),
            .b_size (ld_size),
            .hit    (hit[i])
        );
    end

    // The store being accepted this cycle is not yet in mem but already blocks loads.
    sb_overlap_cmp #(
        .ADDRW(ADDRW),
        .SIZEW(SIZEW)
    ) u_cmp_incoming (
        .en     (push),
        .a_addr (st_address),
        .a_size (st_size),
        .b_addr (ld_address),
        .b_size (ld_size),
        .hit    (hit[DEPTH])
    );

    assign ld_conflict = |hit;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;
    localparam int DATAW = 64;
    localparam int SIZEW = 4;
    localparam int ADDRW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             st_valid;
    logic             st_ready;
    logic [ADDRW-1:0] st_address;
    logic [DATAW-1:0] st_data;
    logic [SIZEW-1:0] st_size;
    logic             dmem_w_valid;
    logic             dmem_w_ready;
    logic [ADDRW-1:0] dmem_w_address;
    logic             dmem_w_wr_en;
    logic [DATAW-1:0] dmem_w_wr_data;
    logic [SIZEW-1:0] dmem_w_wr_size;
    logic [ADDRW-1:0] ld_address;
    logic [SIZEW-1:0] ld_size;
    logic             ld_conflict;
    logic             sb_empty;
    logic [PTRW:0]    sb_count;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH(DEPTH), .PTRW(PTRW), .DATAW(DATAW), .SIZEW(SIZEW), .ADDRW(ADDRW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_address     (st_address),
        .st_data        (st_data),
        .st_size        (st_size),
        .dmem_w_valid   (dmem_w_valid),
        .dmem_w_ready   (dmem_w_ready),
        .dmem_w_address (dmem_w_address),
        .dmem_w_wr_en   (dmem_w_wr_en),
        .dmem_w_wr_data (dmem_w_wr_data),
        .dmem_w_wr_size (dmem_w_wr_size),
        .ld_address     (ld_address),
        .ld_size        (ld_size),
        .ld_conflict    (ld_conflict),
        .sb_empty       (sb_empty),
        .sb_count       (sb_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  size;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   emitted = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte intersection in 32-bit address space.
    function automatic bit bytes_overlap(input logic [31:0] a, input logic [3:0] s,
                                         input logic [31:0] b, input logic [3:0] l);
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < int'(l); i++) begin
            for (int j = 0; j < int'(s); j++) begin
                x = b + 32'(i);
                y = a + 32'(j);
                if (x == y) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic probe();
        bit ready_e;
        bit valid_e;
        bit conf_e;
        @(negedge clk);
        ready_e = !reset && (q.size() < DEPTH);
        valid_e = !reset && (q.size() > 0);
        conf_e  = 1'b0;
        if (!reset) begin
            foreach (q[k]) begin
                if (bytes_overlap(q[k].addr, q[k].size, ld_address, ld_size)) conf_e = 1'b1;
            end
            if (st_valid && ready_e && bytes_overlap(st_address, st_size, ld_address, ld_size))
                conf_e = 1'b1;
        end
        chk("st_ready", st_ready, ready_e);
        chk("dmem_w_valid", dmem_w_valid, valid_e);
        chk("dmem_w_wr_en", dmem_w_wr_en, valid_e);
        chk("sb_empty", sb_empty, reset || q.size() == 0);
        chk("sb_count", sb_count, reset ? 0 : q.size());
        chk("ld_conflict", ld_conflict, conf_e);
        if (valid_e) begin
            chk("head_address", dmem_w_address, q[0].addr);
            chk("head_data", dmem_w_wr_data, q[0].data);
            chk("head_size", dmem_w_wr_size, q[0].size);
        end
    endtask

    task automatic commit();
        bit   push;
        bit   pop;
        ent_t tmp;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            push = st_valid && (q.size() < DEPTH);
            pop  = dmem_w_ready && (q.size() > 0);
            if (pop) begin
                tmp = q.pop_front();
                emitted++;
            end
            if (push) q.push_back('{st_address, st_data, st_size});
        end
        #1;
    endtask

    task automatic tick();
        probe();
        commit();
    endtask

    task automatic set_store(input logic [31:0] a, input logic [3:0] s);
        st_valid   = 1'b1;
        st_address = a;
        st_size    = s;
        st_data    = {$urandom, $urandom};
    endtask

    initial begin
        int pushed;
        int start_emit;
        int cyc;
        bit accepted;

        reset        = 1'b1;
        st_valid     = 1'b0;
        st_address   = '0;
        st_data      = '0;
        st_size      = '0;
        dmem_w_ready = 1'b0;
        ld_address   = '0;
        ld_size      = '0;

        // Reset state
        tick();
        probe();
        chk("rst_st_ready", st_ready, 0);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_sb_count", sb_count, 0);
        commit();
        reset = 1'b0;
        probe();
        chk("st_ready_after_reset", st_ready, 1);
        commit();

        // Fill four with ready low, then drain in order
        set_store(32'h100, 4'd8); tick();
        set_store(32'h108, 4'd8); tick();
        set_store(32'h110, 4'd4); tick();
        set_store(32'h200, 4'd1); tick();
        st_valid = 1'b0;
        probe();
        chk("full_st_ready", st_ready, 0);
        chk("full_sb_count", sb_count, 4);
        commit();
        dmem_w_ready = 1'b1;
        probe();
        chk("drain_first_addr", dmem_w_address, 32'h100);
        commit();
        repeat (3) tick();
        probe();
        chk("drained_empty", sb_empty, 1);
        commit();

        // Full buffer with push attempt and pop in the same cycle
        dmem_w_ready = 1'b0;
        repeat (4) begin
            set_store(32'h300 + 32'($urandom_range(0, 255)), 4'($urandom_range(1, 8)));
            tick();
        end
        set_store(32'h380, 4'd8);
        dmem_w_ready = 1'b1;
        probe();
        chk("full_pop_st_ready", st_ready, 0);
        commit();
        probe();
        chk("after_pop_count", sb_count, 3);
        chk("after_pop_ready", st_ready, 1);
        commit();
        st_valid = 1'b0;
        probe();
        chk("push_pop_count", sb_count, 3);
        commit();
        repeat (3) tick();

        // Overlap against a pending store
        dmem_w_ready = 1'b0;
        set_store(32'h1004, 4'd4); tick();
        st_valid = 1'b0;
        ld_address = 32'h1000; ld_size = 4'd4;
        probe(); chk("ovl_1000_4", ld_conflict, 0); commit();
        ld_address = 32'h1006; ld_size = 4'd1;
        probe(); chk("ovl_1006_1", ld_conflict, 1); commit();
        ld_address = 32'h1000; ld_size = 4'd8;
        probe(); chk("ovl_1000_8", ld_conflict, 1); commit();
        ld_address = 32'h1004; ld_size = 4'd0;
        probe(); chk("ovl_size0", ld_conflict, 0); commit();

        // Address-space wrap and incoming-store overlap
        set_store(32'hFFFF_FFFE, 4'd4); tick();
        st_valid = 1'b0;
        ld_address = 32'h0; ld_size = 4'd1;
        probe(); chk("ovl_wrap", ld_conflict, 1); commit();
        dmem_w_ready = 1'b1;
        ld_size = 4'd0;
        repeat (2) tick();
        dmem_w_ready = 1'b0;
        set_store(32'h40, 4'd2);
        ld_address = 32'h41; ld_size = 4'd1;
        probe(); chk("ovl_incoming", ld_conflict, 1); commit();
        st_valid = 1'b0;
        ld_size = 4'd0;
        dmem_w_ready = 1'b1;
        repeat (2) tick();

        // Random streaming with ready toggling 1-0-1 and random load probes
        pushed = 0;
        start_emit = emitted;
        cyc = 0;
        while (cyc < 300 && (pushed < 3 * DEPTH || q.size() > 0)) begin
            if (pushed < 3 * DEPTH && $urandom_range(0, 3) != 0)
                set_store(32'h2000 + 32'($urandom_range(0, 63)), 4'($urandom_range(0, 15)));
            else
                st_valid = 1'b0;
            dmem_w_ready = (cyc % 3) != 1;
            ld_address = 32'h2000 + 32'($urandom_range(0, 63));
            ld_size = 4'($urandom_range(0, 8));
            accepted = st_valid && (q.size() < DEPTH);
            tick();
            if (accepted) pushed++;
            cyc++;
        end
        st_valid = 1'b0;
        ld_size = 4'd0;
        chk("rand_all_pushed", pushed, 3 * DEPTH);
        chk("rand_all_emitted", emitted - start_emit, 3 * DEPTH);
        probe();
        chk("rand_end_empty", sb_empty, 1);
        commit();

        // Reset with three resident entries
        dmem_w_ready = 1'b0;
        repeat (3) begin
            set_store(32'h5000 + 32'($urandom_range(0, 255)), 4'd4);
            tick();
        end
        st_valid = 1'b0;
        probe(); chk("pre_reset_valid", dmem_w_valid, 1); commit();
        reset = 1'b1;
        dmem_w_ready = 1'b1;
        tick();
        probe();
        chk("mid_reset_valid", dmem_w_valid, 0);
        chk("mid_reset_count", sb_count, 0);
        chk("mid_reset_empty", sb_empty, 1);
        chk("mid_reset_st_ready", st_ready, 0);
        commit();
        reset = 1'b0;
        probe();
        chk("post_reset_st_ready", st_ready, 1);
        chk("post_reset_valid", dmem_w_valid, 0);
        commit();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
